// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution layer controller: state encoding and layer sizing.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_KWAIT  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Weight words per layer: a 3x3 kernel per channel per filter, plus one bias per filter.
  function automatic int calc_nk(input int chanel, input int filter);
    return 9 * chanel * filter + filter;
  endfunction

  // Pixels per image.
  function automatic int calc_np(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/conv_ctrl_rdseq.sv
// Counted read sequencer: issues N read strobes with addresses 0..N-1 after a go pulse.
// Latency: first strobe the cycle after go_i; last_o flags the N-th strobe.
// Backpressure: pause_i suppresses the strobe combinationally; the address holds until the read is issued.
module conv_ctrl_rdseq #(
  parameter int N  = 16,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          go_i,
  input  logic          pause_i,
  output logic          rd_o,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  logic          active_q;
  logic [AW-1:0] cnt_q;

  assign rd_o   = active_q & ~pause_i;
  assign addr_o = cnt_q;
  assign last_o = rd_o && (cnt_q == AW'(N - 1));

  // Arm on go, advance on every issued read, disarm and rewind after the last one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (go_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
    end else if (rd_o) begin
      if (last_o) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + AW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_layer_ctrl.sv
// Layer pass controller: loads weights (unless skipped), streams the image, waits for the array to finish.
// Latency: first read the cycle after start; load_kernel/data_valid_in trail their read strobes by one cycle.
// Backpressure: pause stalls pixel issue cycle by cycle; CONV_CTRL_WDOG_EN adds a watchdog on the two wait states.
module conv_layer_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int HEIGHT  = 16,
  parameter int CHANEL  = 4,
  parameter int FILTER  = 8,
  parameter int KADDR_W = 9,
  parameter int PADDR_W = 8
`ifdef CONV_CTRL_WDOG_EN
  ,
  parameter int WDOG_CYCLES = 4096
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  skip_kernel,
  input  logic                  pause,
  output logic                  busy,
  output logic                  layer_done,
  output logic                  w_rd,
  output logic [KADDR_W-1:0]    w_addr,
  input  logic [31:0]           w_data,
  output logic                  load_kernel,
  output logic [31:0]           kernel,
  input  logic                  load_kernel_done,
  output logic                  px_rd,
  output logic [PADDR_W-1:0]    px_addr,
  input  logic [32*CHANEL-1:0]  px_data,
  output logic                  data_valid_in,
  output logic [32*CHANEL-1:0]  conv_data,
  input  logic                  conv_valid_out,
  input  logic                  done_img,
  output logic [31:0]           out_count
`ifdef CONV_CTRL_WDOG_EN
  ,
  output logic                  wdog_err
`endif
);

  localparam int NK = calc_nk(CHANEL, FILTER);
  localparam int NP = calc_np(WIDTH, HEIGHT);

  state_e      state_q;
  logic        busy_q, layer_done_q, done_seen_q;
  logic        load_kernel_q, data_valid_q;
  logic [31:0] out_count_q;
  logic        w_go, px_go, w_last, px_last, img_ok, wdog_fire;

  assign w_go   = (state_q == S_IDLE) && start && !skip_kernel;
  assign px_go  = ((state_q == S_IDLE) && start && skip_kernel) ||
                  ((state_q == S_KWAIT) && load_kernel_done);
  // An image-complete pulse seen while pixels were still going out counts as arrived.
  assign img_ok = done_img | done_seen_q;

  conv_ctrl_rdseq #(.N(NK), .AW(KADDR_W)) u_wseq (
    .clk_i(clk), .rst_i(reset), .go_i(w_go), .pause_i(1'b0),
    .rd_o(w_rd), .addr_o(w_addr), .last_o(w_last)
  );

  conv_ctrl_rdseq #(.N(NP), .AW(PADDR_W)) u_pseq (
    .clk_i(clk), .rst_i(reset), .go_i(px_go), .pause_i(pause),
    .rd_o(px_rd), .addr_o(px_addr), .last_o(px_last)
  );

`ifdef CONV_CTRL_WDOG_EN
  logic [31:0] wdog_cnt_q;
  logic        wdog_err_q;

  assign wdog_fire = (wdog_cnt_q == 32'(WDOG_CYCLES - 1)) &&
                     (((state_q == S_KWAIT) && !load_kernel_done) ||
                      ((state_q == S_DRAIN) && !img_ok));
  assign wdog_err  = wdog_err_q;

  // Count consecutive cycles parked in a wait state; the error flag stays set until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= ((state_q == S_KWAIT) || (state_q == S_DRAIN)) ? wdog_cnt_q + 32'd1 : '0;
      if (wdog_fire) wdog_err_q <= 1'b1;
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

  // The strobes are registered so they line up with the word the memory returns one cycle after the read.
  assign load_kernel   = load_kernel_q;
  assign kernel        = load_kernel_q ? w_data : '0;
  assign data_valid_in = data_valid_q;
  assign conv_data     = data_valid_q ? px_data : '0;
  assign busy          = busy_q;
  assign layer_done    = layer_done_q;
  assign out_count     = out_count_q;

  // Pass sequencing, status outputs and output-beat counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
      done_seen_q   <= 1'b0;
      load_kernel_q <= 1'b0;
      data_valid_q  <= 1'b0;
      out_count_q   <= '0;
    end else begin
      load_kernel_q <= w_rd;
      data_valid_q  <= px_rd;
      if (busy_q && conv_valid_out) out_count_q <= out_count_q + 32'd1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q      <= 1'b1;
            out_count_q <= '0;
            done_seen_q <= 1'b0;
            state_q     <= skip_kernel ? S_STREAM : S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_last) state_q <= S_KWAIT;
        end
        S_KWAIT: begin
          if (load_kernel_done) begin
            state_q <= S_STREAM;
          end else if (wdog_fire) begin
            state_q      <= S_DONE;
            layer_done_q <= 1'b1;
          end
        end
        S_STREAM: begin
          if (done_img) done_seen_q <= 1'b1;
          if (px_last) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (img_ok || wdog_fire) begin
            state_q      <= S_DONE;
            layer_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          layer_done_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Testbench for conv_layer_ctrl: randomized passes checked every cycle against a count-based pass model.
// Latency: not applicable.
// Backpressure: pause is driven randomly and as a forced 3-cycle stall.
module tb_conv_layer_ctrl;

  localparam int WIDTH  = 16;
  localparam int HEIGHT = 16;
  localparam int CHANEL = 4;
  localparam int FILTER = 8;
  localparam int DW     = 32 * CHANEL;
  localparam int NK     = 9 * CHANEL * FILTER + FILTER;  // 296
  localparam int NP     = WIDTH * HEIGHT;                // 256
  localparam int WD     = 64;

  logic            clk, reset, start, skip_kernel, pause;
  logic            busy, layer_done, w_rd, load_kernel, load_kernel_done;
  logic [8:0]      w_addr;
  logic [31:0]     w_data, kernel, out_count;
  logic            px_rd, data_valid_in, conv_valid_out, done_img;
  logic [7:0]      px_addr;
  logic [DW-1:0]   px_data, conv_data;
`ifdef CONV_CTRL_WDOG_EN
  logic            wdog_err;
`endif

  conv_layer_ctrl #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CHANEL(CHANEL), .FILTER(FILTER), .KADDR_W(9), .PADDR_W(8)
`ifdef CONV_CTRL_WDOG_EN
    , .WDOG_CYCLES(WD)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .skip_kernel(skip_kernel), .pause(pause),
    .busy(busy), .layer_done(layer_done), .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .load_kernel(load_kernel), .kernel(kernel), .load_kernel_done(load_kernel_done),
    .px_rd(px_rd), .px_addr(px_addr), .px_data(px_data), .data_valid_in(data_valid_in),
    .conv_data(conv_data), .conv_valid_out(conv_valid_out), .done_img(done_img),
    .out_count(out_count)
`ifdef CONV_CTRL_WDOG_EN
    , .wdog_err(wdog_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory contents seen by the controller.
  function automatic logic [31:0] wfun(input int a);
    return 32'(a) * 32'h9E3779B1 + 32'h00001234;
  endfunction

  function automatic logic [DW-1:0] pfun(input int i);
    logic [DW-1:0] r;
    for (int c = 0; c < CHANEL; c++) r[32*c +: 32] = 32'hC0DE0000 ^ 32'(i * 16 + c);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_px();
    logic [DW-1:0] r;
    for (int c = 0; c < CHANEL; c++) r[32*c +: 32] = $urandom;
    return r;
  endfunction

  // Pass model: counts of weights and pixels issued, and flags for kernel/image acknowledgement.
  bit m_act, m_load, m_kok, m_fin, m_seen, m_werr, m_lk, m_dv;
  int m_wn, m_pn, m_wait, m_lka, m_dvi, m_oc;
  bit e_w_rd, e_px_rd;

  // Observation records.
  bit       mon_w_rd, mon_px_rd, mon_dv;
  int       mon_w_addr, mon_px_addr;
  int       w_cnt, w_first, w_max, lk_cnt, lk_first, px_cnt, px_first, px_last;
  int       p100, dv99, dv100, ld_cnt, ld_cyc, oc_at_ld;

  task automatic clr_mon();
    w_cnt = 0; w_first = -1; w_max = -1; lk_cnt = 0; lk_first = -1;
    px_cnt = 0; px_first = -1; px_last = -1; p100 = 0; dv99 = -1; dv100 = -1;
    ld_cnt = 0; ld_cyc = -1; oc_at_ld = -1;
  endtask

  // Per-cycle compare against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    bit waiting_k, pix_done, prog;
    if (reset) begin
      m_act = 0; m_load = 0; m_kok = 0; m_fin = 0; m_seen = 0; m_werr = 0;
      m_lk = 0; m_dv = 0; m_wn = 0; m_pn = 0; m_wait = 0; m_oc = 0;
      chk("rst_w_addr", DW'(w_addr), '0);
      chk("rst_px_addr", DW'(px_addr), '0);
      chk("rst_kernel", DW'(kernel), '0);
      chk("rst_conv_data", conv_data, '0);
    end
    e_w_rd  = m_act && !m_fin && m_load && (m_wn < NK);
    e_px_rd = m_act && !m_fin && m_kok && (m_pn < NP) && !pause;
    chk("busy", DW'(busy), DW'(m_act));
    chk("layer_done", DW'(layer_done), DW'(m_fin));
    chk("w_rd", DW'(w_rd), DW'(e_w_rd));
    if (e_w_rd) chk("w_addr", DW'(w_addr), DW'(m_wn));
    chk("px_rd", DW'(px_rd), DW'(e_px_rd));
    if (e_px_rd) chk("px_addr", DW'(px_addr), DW'(m_pn));
    chk("load_kernel", DW'(load_kernel), DW'(m_lk));
    if (m_lk) chk("kernel", DW'(kernel), DW'(wfun(m_lka)));
    chk("data_valid_in", DW'(data_valid_in), DW'(m_dv));
    if (m_dv) chk("conv_data", conv_data, pfun(m_dvi));
    chk("out_count", DW'(out_count), DW'(m_oc));
`ifdef CONV_CTRL_WDOG_EN
    chk("wdog_err", DW'(wdog_err), DW'(m_werr));
`endif

    if (w_rd) begin
      w_cnt++;
      if (w_first < 0) w_first = cyc;
      if (int'(w_addr) > w_max) w_max = int'(w_addr);
    end
    if (load_kernel) begin
      lk_cnt++;
      if (lk_first < 0) lk_first = cyc;
    end
    if (px_rd) begin
      px_cnt++;
      if (px_first < 0) px_first = cyc;
      px_last = cyc;
    end
    if (data_valid_in && conv_data == pfun(99)) dv99 = cyc;
    if (data_valid_in && conv_data == pfun(100)) begin p100++; dv100 = cyc; end
    if (layer_done) begin ld_cnt++; ld_cyc = cyc; oc_at_ld = int'(out_count); end
    mon_w_rd = w_rd; mon_w_addr = int'(w_addr);
    mon_px_rd = px_rd; mon_px_addr = int'(px_addr);
    mon_dv = data_valid_in;

    if (!reset) begin
      m_lk = e_w_rd; m_lka = m_wn;
      m_dv = e_px_rd; m_dvi = m_pn;
      if (!m_act && start) m_oc = 0;
      else if (m_act && conv_valid_out) m_oc++;
      if (m_fin) begin
        m_act = 0; m_fin = 0;
      end else if (!m_act && start) begin
        m_act = 1; m_load = !skip_kernel; m_kok = skip_kernel;
        m_wn = 0; m_pn = 0; m_seen = 0; m_wait = 0;
      end else if (m_act) begin
        waiting_k = m_load && (m_wn == NK) && !m_kok;
        pix_done  = m_kok && (m_pn == NP);
        prog      = (waiting_k && load_kernel_done) || (pix_done && (done_img || m_seen));
        if (e_w_rd) m_wn++;
        if (e_px_rd) m_pn++;
        if (waiting_k && load_kernel_done) m_kok = 1;
        if (pix_done && (done_img || m_seen)) m_fin = 1;
        else if (m_kok && !pix_done && done_img) m_seen = 1;
`ifdef CONV_CTRL_WDOG_EN
        if ((waiting_k || pix_done) && !prog) begin
          m_wait++;
          if (m_wait == WD) begin m_werr = 1; m_fin = 1; end
        end else begin
          m_wait = 0;
        end
`endif
      end
    end
    cyc++;
  end

  bit echo, rnd_pause, rnd_start;

  // Advance one cycle: the memories answer last cycle's reads, background inputs get fresh random values.
  task automatic step();
    @(posedge clk); #1;
    w_data           = mon_w_rd ? wfun(mon_w_addr) : $urandom;
    px_data          = mon_px_rd ? pfun(mon_px_addr) : rand_px();
    conv_valid_out   = echo ? mon_dv : ($urandom % 3 == 0);
    start            = rnd_start && m_act && !m_fin && ($urandom % 16 == 0);
    pause            = rnd_pause && ($urandom % 5 == 0);
    skip_kernel      = ($urandom % 2 == 0);
    load_kernel_done = 1'b0;
    done_img         = 1'b0;
  endtask

  task automatic chk_to(input string nm, input int k);
    bit ok;
    ok = (k < 3000);
    chk(nm, DW'(ok), DW'(1));
  endtask

  task automatic wait_w_done(input string nm);
    int k = 0;
    while (!(m_act && m_load && m_wn == NK && !m_kok) && k < 3000) begin step(); k++; end
    chk_to(nm, k);
  endtask

  task automatic wait_px(input int n, input string nm);
    int k = 0;
    while (!(m_act && m_kok && m_pn == n) && k < 3000) begin step(); k++; end
    chk_to(nm, k);
  endtask

  task automatic wait_ld(input string nm);
    int k = 0;
    while (ld_cnt == 0 && k < 3000) begin step(); k++; end
    chk_to(nm, k);
  endtask

  int t_start, t_kd;

  initial begin
    reset = 1; start = 0; skip_kernel = 0; pause = 0; load_kernel_done = 0;
    done_img = 0; conv_valid_out = 0; w_data = 0; px_data = '0;
    echo = 0; rnd_pause = 0; rnd_start = 0;
    clr_mon();
    repeat (3) step();
    reset = 0;
    step();
    chk("idle_busy", DW'(busy), DW'(0));
    chk("idle_out_count", DW'(out_count), DW'(0));

    // Pass A: full weight load, late kernel ack, forced pause at pixel 100.
    clr_mon(); echo = 1; rnd_start = 1;
    step(); start = 1; skip_kernel = 0; t_start = cyc;
    wait_w_done("to_a_weights");
    repeat (4) step();
    step(); load_kernel_done = 1; t_kd = cyc;
    chk("a_w_count", DW'(w_cnt), DW'(296));
    chk("a_w_first", DW'(w_first), DW'(t_start + 1));
    chk("a_w_last_addr", DW'(w_max), DW'(295));
    chk("a_lk_count", DW'(lk_cnt), DW'(296));
    chk("a_lk_first", DW'(lk_first), DW'(t_start + 2));
    chk("a_no_px_before_ack", DW'(px_cnt), DW'(0));
    wait_px(100, "to_a_px100");
    pause = 1; step(); pause = 1; step(); pause = 1;
    wait_px(NP, "to_a_pixels");
    repeat (6) step();
    step(); done_img = 1;
    wait_ld("to_a_done");
    chk("a_px_first", DW'(px_first), DW'(t_kd + 1));
    chk("a_px_count", DW'(px_cnt), DW'(256));
    chk("a_px100_once", DW'(p100), DW'(1));
    chk("a_gap_99_100", DW'(dv100 - dv99), DW'(4));
    chk("a_out_count", DW'(oc_at_ld), DW'(256));
    repeat (2) step();
    chk("a_ld_pulses", DW'(ld_cnt), DW'(1));
    chk("a_busy_after", DW'(busy), DW'(0));

    // Pass B: reuse weights, random pause, done_img with the final data_valid_in.
    clr_mon(); echo = 0; rnd_pause = 1;
    step(); start = 1; skip_kernel = 1;
    wait_px(NP, "to_b_pixels");
    done_img = 1;
    wait_ld("to_b_done");
    repeat (2) step();
    chk("b_no_w_rd", DW'(w_cnt), DW'(0));
    chk("b_px_count", DW'(px_cnt), DW'(256));
    chk("b_ld_pulses", DW'(ld_cnt), DW'(1));

    // Pass C: reset in the middle of streaming.
    clr_mon();
    step(); start = 1; skip_kernel = 1;
    wait_px(50, "to_c_px50");
    reset = 1;
    @(negedge clk); #1;
    chk("c_rst_busy", DW'(busy), DW'(0));
    chk("c_rst_px_rd", DW'(px_rd), DW'(0));
    chk("c_rst_dv", DW'(data_valid_in), DW'(0));
    chk("c_rst_out_count", DW'(out_count), DW'(0));
    step(); step(); reset = 0;
    step();

    // Pass D: fresh start with random acknowledgement delays.
    clr_mon();
    step(); start = 1; skip_kernel = 0;
    wait_w_done("to_d_weights");
    repeat ($urandom_range(0, 10)) step();
    step(); load_kernel_done = 1;
    wait_px(NP, "to_d_pixels");
    repeat ($urandom_range(0, 8)) step();
    step(); done_img = 1;
    wait_ld("to_d_done");
    repeat (2) step();
    chk("d_w_count", DW'(w_cnt), DW'(296));
    chk("d_px_count", DW'(px_cnt), DW'(256));
    chk("d_ld_pulses", DW'(ld_cnt), DW'(1));

`ifdef CONV_CTRL_WDOG_EN
    // Pass E: done_img withheld, the watchdog ends the pass.
    clr_mon(); rnd_pause = 0;
    step(); start = 1; skip_kernel = 1;
    wait_px(NP, "to_e_pixels");
    wait_ld("to_e_done");
    chk("e_wdog_err", DW'(wdog_err), DW'(1));
    chk("e_drain_len", DW'(ld_cyc - px_last), DW'(65));
    repeat (3) step();
    chk("e_wdog_sticky", DW'(wdog_err), DW'(1));
    chk("e_busy_after", DW'(busy), DW'(0));
`endif

    rnd_start = 0; rnd_pause = 0;
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: actual cycle %0d required end of test", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

endmodule
